q_op_issue_ctrl: RTL and testbench
==================================

# q_op_issue_ctrl

Sequencer in front of the quantum-register decoder. Accepts timed quantum-op instructions through a valid/ready port and buffers them in a small FIFO. Each op is held back for its programmed wait interval, then the controller reads the single/double-qubit register files and presents the decoded op to the downstream pulse stage with a valid/ready handshake. It drives the decoder's `reg_read_addr`, `reg_off` and `q_reg_sel` inputs.

## Interface
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, ≥2.
- `WAIT_W`, 16: width of the per-instruction wait field.
- `clk` input 1: clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `instr_valid` input 1: instruction offered.
- `instr_ready` output 1: instruction accepted when both high.
- `instr_type` input 2: 01 single-qubit, 10 double-qubit; 00/11 illegal.
- `instr_addr` input 5: register read address; bit 4 = long register.
- `instr_off` input 5: short-register qubit offset (units of 4 qubits).
- `instr_wait` input WAIT_W: idle cycles inserted before the register read.
- `reg_rd_en` output 1: register-file read strobe (sync read, 1-cycle latency).
- `reg_read_addr` output 5: to register files and decoder.
- `reg_off` output 5: to decoder.
- `q_reg_sel` output 2: to decoder; 01 single, 10 double, 00 otherwise.
- `op_valid` output 1: decoded op on decoder output is valid.
- `op_ready` input 1: downstream takes op when both high.
- `busy` output 1: FIFO non-empty or FSM not IDLE.
- `err_illegal` output 1: one-cycle pulse on a dropped illegal instruction.
- `issue_cnt` output 16: count of completed op handshakes, wraps.

## Operation
- Legality is checked at acceptance. Illegal: `instr_type` ∈ {00,11}, or type 01 with `instr_addr[4]`=0 and `instr_off` > 16. 8·off+91 must be ≤ 219.
- An illegal instruction is still handshaken (`instr_ready` high). It is not enqueued, and `err_illegal` pulses in the following cycle.
- `instr_ready` = FIFO not full; it does not depend on `instr_valid`. Push and pop can occur in the same cycle. The occupancy count is unchanged in that case.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head and latch type/addr/off. Go to READ if wait = 0, else load the counter with wait and go to WAIT.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to READ, which is exactly `instr_wait` cycles in WAIT.
  - READ: `reg_rd_en`=1 for exactly one cycle with the latched address. Next state is ISSUE.
  - ISSUE: `q_reg_sel` = latched type and `op_valid`=1. Hold all outputs stable until `op_ready`. On the handshake, increment `issue_cnt` and go to IDLE.
- `reg_read_addr` and `reg_off` are registered. They change only on a pop and are stable through WAIT, READ and ISSUE. `reg_off` is passed through unmodified for long/double ops; the decoder ignores it.
- `q_reg_sel` is 00 and `op_valid` is 0 in every state except ISSUE.
- FIFO wrap-around uses a pointer modulo `FIFO_DEPTH`. Full and empty are distinguished by a separate occupancy count.

## Timing
- Reset values: `instr_ready`=1, `reg_rd_en`=0, `reg_read_addr`=0, `reg_off`=0, `q_reg_sel`=00, `op_valid`=0, `busy`=0, `err_illegal`=0, `issue_cnt`=0. FSM goes to IDLE and the FIFO empties.
- Reset asserted mid-operation discards all buffered and in-flight ops. No partial handshake completes.
- With the FIFO empty and FSM in IDLE, an instruction accepted at edge t with wait W proceeds as follows:
  - popped at t+1;
  - READ cycle at t+2+W;
  - `op_valid` high from t+3+W.
- Minimum issue spacing is 3 cycles per op (IDLE, READ, ISSUE) with W=0 and `op_ready` held high.
- Back-pressure: `op_ready` low holds ISSUE indefinitely. The FIFO keeps accepting until full.
- `err_illegal` is registered, one cycle after the illegal handshake. Back-to-back illegal instructions give back-to-back pulses.

## Test plan
- Reset then single op: type 01, addr 0x03, off 2, wait 0, `op_ready`=1.
  - Required: `reg_rd_en` one cycle at t+2 with `reg_read_addr`=0x03 and `reg_off`=2.
  - Required: `q_reg_sel`=01 and `op_valid` for one cycle at t+3; `issue_cnt`=1.
- Wait timing: double op, addr 0x12, wait 5.
  - Required: READ at t+7, `q_reg_sel`=10 at t+8, and `reg_read_addr` stable at 0x12 from t+1 to the handshake.
- FIFO full/back-pressure: `op_ready`=0, push 6 ops at `FIFO_DEPTH`=4.
  - Required: `instr_ready` drops after 5 accepts (1 popped plus 4 buffered).
  - Required: release `op_ready` and all 5 issue in order; `issue_cnt`=5, then `busy`=0.
- Illegal drops: push type 11; then type 01, addr 0x05, off 17; then type 01, addr 0x15, off 17.
  - Required: two `err_illegal` pulses, and only the third op (long, offset ignored) issues.
- Simultaneous push/pop at full plus pointer wrap: stream 20 ops with random waits 0–3 and random `op_ready`.
  - Required: issue order matches push order and no op is lost or duplicated.
  - Required: `issue_cnt` wraps correctly when preloaded near 0xFFFF via 65535 ops or a force.
- Reset mid-ISSUE with 2 ops queued.
  - Required: all outputs return to reset values asynchronously.
  - Required: no `op_valid` after reset release until a new instruction is pushed.

Source files
------------

// File: rtl/q_op_issue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// q_op_issue_ctrl
//
// Sequencer in front of the quantum-register decoder. Timed quantum-op
// instructions arrive on a valid/ready port and are checked for legality.
// Legal ones are buffered in a small FIFO. Each op is held for its programmed
// wait interval, then the register files are read for one cycle. The decoded
// op is then offered downstream with a valid/ready handshake.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   instr_valid/ready   instruction handshake; ready = FIFO not full
//   instr_type          01 single-qubit, 10 double-qubit, 00/11 illegal
//   instr_addr          register read address, bit 4 selects a long register
//   instr_off           short-register qubit offset (units of 4 qubits)
//   instr_wait          idle cycles inserted before the register read
//   reg_rd_en           one-cycle read strobe to the register files
//   reg_read_addr       registered read address to register files / decoder
//   reg_off             registered qubit offset to the decoder
//   q_reg_sel           decoder select: 01 single, 10 double, 00 when idle
//   op_valid/op_ready   decoded-op handshake to the pulse stage
//   busy                FIFO non-empty or sequencer not idle
//   err_illegal         one-cycle pulse after an illegal instruction is dropped
//   issue_cnt           completed op handshakes, wraps at 16 bits
// -----------------------------------------------------------------------------
module q_op_issue_ctrl #(
   parameter int FIFO_DEPTH = 4,
   parameter int WAIT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_type,
   input  logic [4:0]        instr_addr,
   input  logic [4:0]        instr_off,
   input  logic [WAIT_W-1:0] instr_wait,
   output logic              reg_rd_en,
   output logic [4:0]        reg_read_addr,
   output logic [4:0]        reg_off,
   output logic [1:0]        q_reg_sel,
   output logic              op_valid,
   input  logic              op_ready,
   output logic              busy,
   output logic              err_illegal,
   output logic [15:0]       issue_cnt
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] TYPE_SINGLE = 2'b01;
   localparam logic [1:0] TYPE_DOUBLE = 2'b10;

   // Largest short-register offset that keeps the 4-qubit group inside the
   // register: 8*off + 91 <= 219  <=>  off <= 16.
   localparam logic [4:0] MAX_SHORT_OFF = 5'd16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_READ,
      S_ISSUE
   } state_t;

   typedef struct packed {
      logic [1:0]        op_type;
      logic [4:0]        addr;
      logic [4:0]        off;
      logic [WAIT_W-1:0] wait_cyc;
   } entry_t;

   // ---------------------------------------------------------------------------
   // Acceptance and legality
   // ---------------------------------------------------------------------------
   logic             instr_legal;
   logic             accept;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   entry_t           fifo_mem [FIFO_DEPTH];
   entry_t           head;
   entry_t           new_entry;

   state_t           state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [1:0]       lat_type;

   assign instr_legal = (instr_type == TYPE_DOUBLE) ||
                        ((instr_type == TYPE_SINGLE) &&
                         (instr_addr[4] || (instr_off <= MAX_SHORT_OFF)));

   assign fifo_empty  = (fifo_cnt == '0);
   assign fifo_full   = (fifo_cnt == CNT_W'(FIFO_DEPTH));

   // Ready is purely a function of occupancy so the upstream can never see a
   // combinational path from its own valid back to ready.
   assign instr_ready = !fifo_full;
   assign accept      = instr_valid && instr_ready;
   assign push        = accept && instr_legal;
   assign pop         = (state == S_IDLE) && !fifo_empty;

   assign new_entry   = '{op_type:  instr_type,
                          addr:     instr_addr,
                          off:      instr_off,
                          wait_cyc: instr_wait};
   assign head        = fifo_mem[rd_ptr];

   assign busy        = !fifo_empty || (state != S_IDLE);

   // ---------------------------------------------------------------------------
   // Instruction buffer
   // ---------------------------------------------------------------------------
   // NOTE: the storage array has no reset; only pointers and occupancy define
   // which entries are meaningful, and leaving the array unreset lets it map
   // onto plain registers or LUT RAM without a reset tree.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= new_entry;
      end
   end

   // NOTE: every register in a clocked block uses <=, so all state updates
   // see the pre-edge values and no block ordering can change behaviour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         // Pointers wrap naturally because FIFO_DEPTH is a power of two.
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         // Simultaneous push and pop leave occupancy unchanged.
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Illegal-instruction pulse
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_illegal <= 1'b0;
      end else begin
         err_illegal <= accept && !instr_legal;
      end
   end

   // ---------------------------------------------------------------------------
   // Issue sequencer: IDLE -> [WAIT] -> READ -> ISSUE -> IDLE
   // All decoder-facing outputs are registered and change together with the
   // state, so downstream sees glitch-free, state-aligned signals.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         lat_type      <= 2'b00;
         reg_rd_en     <= 1'b0;
         reg_read_addr <= 5'd0;
         reg_off       <= 5'd0;
         q_reg_sel     <= 2'b00;
         op_valid      <= 1'b0;
         issue_cnt     <= 16'd0;
      end else begin
         // NOTE: the strobe defaults low every cycle and is only raised on the
         // transition into READ, which keeps it exactly one cycle wide.
         reg_rd_en <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pop) begin
                  lat_type      <= head.op_type;
                  reg_read_addr <= head.addr;
                  // Offset is forwarded unchanged; the decoder ignores it for
                  // long and double ops.
                  reg_off       <= head.off;
                  if (head.wait_cyc == '0) begin
                     state     <= S_READ;
                     reg_rd_en <= 1'b1;
                  end else begin
                     wait_cnt <= head.wait_cyc;
                     state    <= S_WAIT;
                  end
               end
            end

            S_WAIT: begin
               // Leaving when the counter steps from 1 to 0 spends exactly
               // instr_wait cycles in this state.
               wait_cnt <= wait_cnt - WAIT_W'(1);
               if (wait_cnt == WAIT_W'(1)) begin
                  state     <= S_READ;
                  reg_rd_en <= 1'b1;
               end
            end

            S_READ: begin
               // Register files answer one cycle after the strobe, so the
               // decoder output is valid from the next cycle on.
               state     <= S_ISSUE;
               op_valid  <= 1'b1;
               q_reg_sel <= lat_type;
            end

            S_ISSUE: begin
               if (op_ready) begin
                  state     <= S_IDLE;
                  op_valid  <= 1'b0;
                  q_reg_sel <= 2'b00;
                  issue_cnt <= issue_cnt + 16'd1;
               end
            end

            default: begin
               state     <= S_IDLE;
               op_valid  <= 1'b0;
               q_reg_sel <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_q_op_issue_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_q_op_issue_ctrl
//
// Self-checking bench. A transaction-level model (queue of pending ops plus
// the edge number at which the current op left the queue) predicts every
// output each cycle; directed sequences pin absolute timings with literals,
// and a push-order scoreboard checks every downstream handshake.
// -----------------------------------------------------------------------------
module tb_q_op_issue_ctrl;

   localparam int FIFO_DEPTH = 4;
   localparam int WAIT_W     = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              instr_valid = 1'b0;
   logic              instr_ready;
   logic [1:0]        instr_type = 2'b00;
   logic [4:0]        instr_addr = 5'd0;
   logic [4:0]        instr_off = 5'd0;
   logic [WAIT_W-1:0] instr_wait = '0;
   logic              reg_rd_en;
   logic [4:0]        reg_read_addr;
   logic [4:0]        reg_off;
   logic [1:0]        q_reg_sel;
   logic              op_valid;
   logic              op_ready = 1'b0;
   logic              busy;
   logic              err_illegal;
   logic [15:0]       issue_cnt;

   q_op_issue_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .WAIT_W(WAIT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_type(instr_type), .instr_addr(instr_addr),
      .instr_off(instr_off), .instr_wait(instr_wait),
      .reg_rd_en(reg_rd_en), .reg_read_addr(reg_read_addr),
      .reg_off(reg_off), .q_reg_sel(q_reg_sel),
      .op_valid(op_valid), .op_ready(op_ready),
      .busy(busy), .err_illegal(err_illegal), .issue_cnt(issue_cnt)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic bit legal(input logic [1:0] t, input logic [4:0] a, input logic [4:0] o);
      return (t == 2'b10) || (t == 2'b01 && (a[4] || o <= 5'd16));
   endfunction

   typedef struct {
      logic [1:0] t;
      logic [4:0] a;
      logic [4:0] o;
      int         w;
   } op_t;

   // ---------------------------------------------------------------------------
   // Reference model: edge-counted, timing expressed relative to the pop edge.
   // ---------------------------------------------------------------------------
   op_t         mq[$];
   op_t         cur;
   bit          cur_v = 0;
   int          e = 0;
   int          p_edge = 0;
   logic [4:0]  m_addr = 5'd0;
   logic [4:0]  m_off = 5'd0;
   logic        m_err = 1'b0;
   logic [15:0] m_cnt = 16'd0;
   bit          m_acc, m_hs, m_pop;
   op_t         m_new;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         cur_v  = 0;
         e      = 0;
         m_addr = 5'd0;
         m_off  = 5'd0;
         m_err  = 1'b0;
         m_cnt  = 16'd0;
      end else begin
         e++;
         m_acc = instr_valid && (mq.size() < FIFO_DEPTH);
         // op_valid was visible in the cycle ending at this edge
         m_hs  = cur_v && (e >= p_edge + cur.w + 2) && op_ready;
         m_pop = !cur_v && (mq.size() > 0);
         if (m_hs) begin
            cur_v = 0;
            m_cnt = m_cnt + 16'd1;
         end
         if (m_pop) begin
            cur    = mq.pop_front();
            cur_v  = 1;
            p_edge = e;
            m_addr = cur.a;
            m_off  = cur.o;
         end
         m_err = m_acc && !legal(instr_type, instr_addr, instr_off);
         if (m_acc && legal(instr_type, instr_addr, instr_off)) begin
            m_new.t = instr_type;
            m_new.a = instr_addr;
            m_new.o = instr_off;
            m_new.w = int'(instr_wait);
            mq.push_back(m_new);
         end
      end
   end

   // Push-order scoreboard filled by the driver.
   op_t sb[$];

   // ---------------------------------------------------------------------------
   // Per-cycle compare against the model, sampled mid-cycle.
   // ---------------------------------------------------------------------------
   bit   x_rd, x_ov;
   op_t  sb_head;

   always @(negedge clk) begin
      x_rd = cur_v && (e == p_edge + cur.w);
      x_ov = cur_v && (e >= p_edge + cur.w + 1);
      check("instr_ready", 32'(instr_ready), 32'(mq.size() < FIFO_DEPTH));
      check("reg_rd_en", 32'(reg_rd_en), 32'(x_rd));
      check("op_valid", 32'(op_valid), 32'(x_ov));
      check("q_reg_sel", 32'(q_reg_sel), x_ov ? 32'(cur.t) : 32'd0);
      check("reg_read_addr", 32'(reg_read_addr), 32'(m_addr));
      check("reg_off", 32'(reg_off), 32'(m_off));
      check("busy", 32'(busy), 32'(cur_v || mq.size() > 0));
      check("err_illegal", 32'(err_illegal), 32'(m_err));
      check("issue_cnt", 32'(issue_cnt), 32'(m_cnt));
      if (rst_n && op_valid && op_ready) begin
         check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            sb_head = sb.pop_front();
            check("sb_addr", 32'(reg_read_addr), 32'(sb_head.a));
            check("sb_off", 32'(reg_off), 32'(sb_head.o));
            check("sb_type", 32'(q_reg_sel), 32'(sb_head.t));
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver helpers (inputs change 1 ns after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] t, input logic [4:0] a, input logic [4:0] o, input int w);
      int  n = 0;
      op_t x;
      instr_valid = 1'b1;
      instr_type  = t;
      instr_addr  = a;
      instr_off   = o;
      instr_wait  = WAIT_W'(w);
      while (!instr_ready && n < 200) begin
         tick();
         n++;
      end
      check("send_timeout", 32'(n < 200), 32'd1);
      if (legal(t, a, o)) begin
         x.t = t; x.a = a; x.o = o; x.w = w;
         sb.push_back(x);
      end
      tick();
      instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check("wait_idle_timeout", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   int acc;
   int sent;
   int guard;
   op_t r;

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      #2;
      check("rst_instr_ready", 32'(instr_ready), 32'd1);
      check("rst_op_valid", 32'(op_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Single op, wait 0: READ visible after t+1, op_valid after t+2
      op_ready = 1'b1;
      send(2'b01, 5'h03, 5'd2, 0);
      tick();
      check("s_rd_en", 32'(reg_rd_en), 32'd1);
      check("s_addr", 32'(reg_read_addr), 32'h03);
      check("s_off", 32'(reg_off), 32'd2);
      check("s_sel_read", 32'(q_reg_sel), 32'd0);
      tick();
      check("s_op_valid", 32'(op_valid), 32'd1);
      check("s_sel", 32'(q_reg_sel), 32'b01);
      check("s_rd_en_off", 32'(reg_rd_en), 32'd0);
      tick();
      check("s_op_valid_done", 32'(op_valid), 32'd0);
      check("s_issue_cnt", 32'(issue_cnt), 32'd1);
      check("s_busy", 32'(busy), 32'd0);

      // Wait timing: double op, addr 0x12, wait 5
      send(2'b10, 5'h12, 5'd7, 5);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("w_addr_stable", 32'(reg_read_addr), 32'h12);
         check("w_rd_en", 32'(reg_rd_en), 32'(k == 6));
         check("w_sel", 32'(q_reg_sel), (k == 7) ? 32'b10 : 32'd0);
      end
      wait_idle(20);
      check("w_issue_cnt", 32'(issue_cnt), 32'd2);

      // FIFO full with back-pressure
      op_ready = 1'b0;
      acc = 0;
      instr_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         instr_type = 2'b01;
         instr_addr = 5'(5'h10 + i);
         instr_off  = 5'(i);
         instr_wait = '0;
         if (!instr_ready) break;
         r.t = 2'b01; r.a = 5'(5'h10 + i); r.o = 5'(i); r.w = 0;
         sb.push_back(r);
         tick();
         acc++;
      end
      instr_valid = 1'b0;
      check("f_accepts", 32'(acc), 32'd5);
      check("f_ready_low", 32'(instr_ready), 32'd0);
      check("f_holding", 32'(op_valid), 32'd1);
      repeat (5) tick();
      check("f_still_holding", 32'(op_valid), 32'd1);
      op_ready = 1'b1;
      wait_idle(100);
      check("f_issue_cnt", 32'(issue_cnt), 32'd7);

      // Illegal drops, back-to-back
      send(2'b11, 5'h01, 5'd0, 0);
      check("i_err1", 32'(err_illegal), 32'd1);
      send(2'b01, 5'h05, 5'd17, 0);
      check("i_err2", 32'(err_illegal), 32'd1);
      send(2'b01, 5'h15, 5'd17, 0);
      check("i_err3", 32'(err_illegal), 32'd0);
      wait_idle(20);
      check("i_issue_cnt", 32'(issue_cnt), 32'd8);
      check("i_addr", 32'(reg_read_addr), 32'h15);
      check("i_off", 32'(reg_off), 32'd17);

      // Random stream with simultaneous push/pop and pointer wrap
      sent = 0;
      guard = 0;
      while (sent < 20 && guard < 2000) begin
         op_ready = ($urandom % 3) != 0;
         if (($urandom % 4) != 0) begin
            r.t = ($urandom % 2) ? 2'b01 : 2'b10;
            r.a = 5'($urandom);
            r.o = 5'($urandom_range(0, 16));
            r.w = int'($urandom_range(0, 3));
            instr_valid = 1'b1;
            instr_type  = r.t;
            instr_addr  = r.a;
            instr_off   = r.o;
            instr_wait  = WAIT_W'(r.w);
            if (instr_ready) begin
               sb.push_back(r);
               sent++;
            end
         end else begin
            instr_valid = 1'b0;
         end
         tick();
         guard++;
      end
      instr_valid = 1'b0;
      op_ready = 1'b1;
      check("r_sent", 32'(sent), 32'd20);
      wait_idle(400);
      check("r_issue_cnt", 32'(issue_cnt), 32'd28);
      check("r_sb_empty", 32'(sb.size()), 32'd0);

      // issue_cnt wrap via preload
      force dut.issue_cnt = 16'hFFFE;
      m_cnt = 16'hFFFE;
      #1 release dut.issue_cnt;
      tick();
      send(2'b10, 5'h0A, 5'd0, 0);
      wait_idle(20);
      check("c_ffff", 32'(issue_cnt), 32'hFFFF);
      send(2'b10, 5'h0B, 5'd0, 1);
      wait_idle(20);
      check("c_wrap", 32'(issue_cnt), 32'h0000);

      // Reset mid-ISSUE with 2 ops queued
      op_ready = 1'b0;
      send(2'b01, 5'h01, 5'd1, 0);
      send(2'b01, 5'h02, 5'd2, 0);
      send(2'b01, 5'h03, 5'd3, 0);
      guard = 0;
      while (!op_valid && guard < 20) begin
         tick();
         guard++;
      end
      check("m_in_issue", 32'(op_valid), 32'd1);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("m_instr_ready", 32'(instr_ready), 32'd1);
      check("m_rd_en", 32'(reg_rd_en), 32'd0);
      check("m_addr", 32'(reg_read_addr), 32'd0);
      check("m_off", 32'(reg_off), 32'd0);
      check("m_sel", 32'(q_reg_sel), 32'd0);
      check("m_op_valid", 32'(op_valid), 32'd0);
      check("m_busy", 32'(busy), 32'd0);
      check("m_err", 32'(err_illegal), 32'd0);
      check("m_issue_cnt", 32'(issue_cnt), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      op_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("m_quiet_valid", 32'(op_valid), 32'd0);
         check("m_quiet_busy", 32'(busy), 32'd0);
      end
      send(2'b10, 5'h1C, 5'd4, 2);
      wait_idle(20);
      check("m_recover_cnt", 32'(issue_cnt), 32'd1);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
